// File: rtl/pwm_pkg.sv
// Shared config record, LFSR taps and on-time clamp for pwm_duty_gen.
// PWM_DUTY_RAND_EN adds the random on-time bounds to cfg_t.
package pwm_pkg;

  localparam int MAX_W = 16;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  // Counter-domain values are held at the widest legal width; narrower
  // configs are zero-extended, which keeps all comparisons exact.
  typedef logic [MAX_W-1:0] cnt_t;

  typedef struct packed {
    logic en;
    cnt_t period;
    cnt_t ton;
`ifdef PWM_DUTY_RAND_EN
    cnt_t ton_lo;
    logic rnd;
`endif
  } cfg_t;

  function automatic cnt_t clamp(input cnt_t v, input cnt_t lo, input cnt_t hi);
    cnt_t lo_eff;
    lo_eff = (lo > hi) ? hi : lo;
    if (v < lo_eff) begin
      return lo_eff;
    end
    if (v > hi) begin
      return hi;
    end
    return v;
  endfunction

endpackage

// File: rtl/pwm_channel.sv
// One PWM channel: period counter, double-buffered config, registered output (1 cycle after cnt).
// Writes are only issued while nothing is pending; PWM_DUTY_RAND_EN adds per-period random on-time.
module pwm_channel
  import pwm_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic wr_en,
  input  cfg_t wr_cfg,
  input  logic sync_start,
`ifdef PWM_DUTY_RAND_EN
  input  cnt_t rnd_val,
`endif
  output logic pwm_out,
  output logic wrap,
  output logic pending
);

  cfg_t act_q, act_d;
  cfg_t shd_q, shd_d;
  logic pend_q, pend_d;
  cnt_t cnt_q, cnt_d;
  logic pwm_q, pwm_d;
  cnt_t ton_eff;

  logic run;
  logic at_end;
  logic commit;
  logic hi;

`ifdef PWM_DUTY_RAND_EN
  cnt_t ton_q, ton_d;
  assign ton_eff = ton_q;
`else
  assign ton_eff = act_q.ton;
`endif

  always_comb begin
    run    = act_q.en && (act_q.period != '0);
    at_end = run && (cnt_q == act_q.period - cnt_t'(1));
    commit = pend_q && (at_end || !run || sync_start);
    // Subtraction only happens once ton < period is known.
    if (ton_eff == '0) begin
      hi = 1'b0;
    end else if (ton_eff >= act_q.period) begin
      hi = 1'b1;
    end else begin
      hi = (cnt_q >= act_q.period - ton_eff);
    end
  end

  always_comb begin
    act_d  = act_q;
    shd_d  = shd_q;
    pend_d = pend_q;
    cnt_d  = cnt_q;
    pwm_d  = run && hi;
    if (commit) begin
      act_d  = shd_q;
      pend_d = 1'b0;
      cnt_d  = '0;
    end else if (!run || at_end || sync_start) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + cnt_t'(1);
    end
    if (wr_en) begin
      shd_d  = wr_cfg;
      pend_d = 1'b1;
    end
  end

`ifdef PWM_DUTY_RAND_EN
  always_comb begin
    ton_d = ton_q;
    if (commit) begin
      ton_d = shd_q.rnd ? clamp(rnd_val, shd_q.ton_lo, shd_q.ton) : shd_q.ton;
    end else if (at_end && act_q.rnd) begin
      ton_d = clamp(rnd_val, act_q.ton_lo, act_q.ton);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ton_q <= '0;
    end else begin
      ton_q <= ton_d;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      act_q  <= '0;
      shd_q  <= '0;
      pend_q <= 1'b0;
      cnt_q  <= '0;
      pwm_q  <= 1'b0;
    end else begin
      act_q  <= act_d;
      shd_q  <= shd_d;
      pend_q <= pend_d;
      cnt_q  <= cnt_d;
      pwm_q  <= pwm_d;
    end
  end

  assign pwm_out = pwm_q;
  assign wrap    = at_end;
  assign pending = pend_q;

endmodule

// File: rtl/pwm_duty_gen.sv
// N-channel duty-cycle/PWM generator; pwm_out registered one cycle after each channel counter.
// cfg_ready drops while the addressed channel has a pending shadow; PWM_DUTY_RAND_EN adds LFSR on-time.
module pwm_duty_gen
  import pwm_pkg::*;
#(
  parameter int          NCH   = 4,
  parameter int          CNT_W = 8,
  parameter logic [15:0] SEED  = 16'hACE1,
  parameter int          CH_W  = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [CH_W-1:0]  cfg_ch,
  input  logic             cfg_en,
  input  logic [CNT_W-1:0] cfg_period,
  input  logic [CNT_W-1:0] cfg_ton,
`ifdef PWM_DUTY_RAND_EN
  input  logic [CNT_W-1:0] cfg_ton_lo,
  input  logic             cfg_rand,
`endif
  input  logic             sync_start,
  output logic [NCH-1:0]   pwm_out,
  output logic [NCH-1:0]   wrap,
  output logic [NCH-1:0]   pending
);

  logic [NCH-1:0] wr_sel;
  cfg_t           wr_cfg;

  // Channel numbers beyond NCH are accepted and dropped so the port never stalls.
  always_comb begin
    cfg_ready = 1'b1;
    wr_sel    = '0;
    for (int i = 0; i < NCH; i++) begin
      if (cfg_ch == CH_W'(i)) begin
        cfg_ready = ~pending[i];
        wr_sel[i] = cfg_valid & ~pending[i];
      end
    end
  end

  always_comb begin
    wr_cfg        = '0;
    wr_cfg.en     = cfg_en;
    wr_cfg.period = cnt_t'(cfg_period);
    wr_cfg.ton    = cnt_t'(cfg_ton);
`ifdef PWM_DUTY_RAND_EN
    wr_cfg.ton_lo = cnt_t'(cfg_ton_lo);
    wr_cfg.rnd    = cfg_rand;
`endif
  end

`ifdef PWM_DUTY_RAND_EN
  logic [15:0] lfsr_q, lfsr_d;
  cnt_t        rnd_val;

  always_comb begin
    lfsr_d = (lfsr_q >> 1) ^ (lfsr_q[0] ? LFSR_TAPS : 16'h0000);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr_q <= SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign rnd_val = cnt_t'(lfsr_q[CNT_W-1:0]);
`else
  // SEED only feeds the LFSR, which is absent in this build.
  logic seed_unused;
  assign seed_unused = ^SEED;
`endif

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    pwm_channel u_ch (
      .clk        (clk),
      .rst        (rst),
      .wr_en      (wr_sel[g]),
      .wr_cfg     (wr_cfg),
      .sync_start (sync_start),
`ifdef PWM_DUTY_RAND_EN
      .rnd_val    (rnd_val),
`endif
      .pwm_out    (pwm_out[g]),
      .wrap       (wrap[g]),
      .pending    (pending[g])
    );
  end

endmodule

// File: tb/tb_pwm_duty_gen.sv
// Scoreboard bench for pwm_duty_gen: directed waveforms then random config traffic.
module tb_pwm_duty_gen;

  localparam int NCH   = 4;
  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             cfg_valid;
  logic             cfg_ready;
  logic [1:0]       cfg_ch;
  logic             cfg_en;
  logic [CNT_W-1:0] cfg_period;
  logic [CNT_W-1:0] cfg_ton;
  logic             sync_start;
  logic [NCH-1:0]   pwm_out;
  logic [NCH-1:0]   wrap;
  logic [NCH-1:0]   pending;

  always #5 clk = ~clk;

  pwm_duty_gen #(.NCH(NCH), .CNT_W(CNT_W), .SEED(16'hACE1)) dut (
    .clk        (clk),
    .rst        (rst),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .cfg_ch     (cfg_ch),
    .cfg_en     (cfg_en),
    .cfg_period (cfg_period),
    .cfg_ton    (cfg_ton),
    .sync_start (sync_start),
    .pwm_out    (pwm_out),
    .wrap       (wrap),
    .pending    (pending)
  );

  typedef struct {
    logic [NCH-1:0] pwm;
    logic [NCH-1:0] wrp;
    logic [NCH-1:0] pnd;
    logic           rdy;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  // Reference model: each channel is a position within its current period
  // plus the active and waiting configurations.
  int a_en[NCH], a_per[NCH], a_ton[NCH];
  int s_en[NCH], s_per[NCH], s_ton[NCH];
  bit pnd[NCH];
  int pos[NCH];
  bit out[NCH];

  bit p_rst, p_v, p_sync;
  int p_ch, p_en, p_per, p_ton;

  int  cnt_hi, cnt_wr;
  bit  counting;
  int  watch_ch;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit active(input int c);
    return (a_en[c] != 0) && (a_per[c] > 0);
  endfunction

  task automatic model_step();
    bit run, last, acc;
    for (int c = 0; c < NCH; c++) begin
      if (p_rst) begin
        a_en[c] = 0; a_per[c] = 0; a_ton[c] = 0;
        s_en[c] = 0; s_per[c] = 0; s_ton[c] = 0;
        pnd[c] = 0; pos[c] = 0; out[c] = 0;
      end else begin
        run  = active(c);
        last = run && (pos[c] == a_per[c] - 1);
        // High during the last ton positions of the period.
        out[c] = run && (pos[c] + a_ton[c] >= a_per[c]);
        acc = p_v && (p_ch == c) && !pnd[c];
        if (pnd[c] && (last || !run || p_sync)) begin
          a_en[c] = s_en[c]; a_per[c] = s_per[c]; a_ton[c] = s_ton[c];
          pnd[c] = 0;
          pos[c] = 0;
        end else if (!run || last || p_sync) begin
          pos[c] = 0;
        end else begin
          pos[c] = pos[c] + 1;
        end
        if (acc) begin
          s_en[c] = p_en; s_per[c] = p_per; s_ton[c] = p_ton;
          pnd[c] = 1;
        end
      end
    end
  endtask

  task automatic step(input bit r, input bit v, input int ch, input int en,
                      input int per, input int ton, input bit sy);
    exp_t e;
    @(posedge clk);
    #1;
    model_step();
    if (counting) begin
      cnt_hi += int'(pwm_out[watch_ch]);
      cnt_wr += int'(wrap[watch_ch]);
    end
    rst        = r;
    cfg_valid  = v;
    cfg_ch     = 2'(ch);
    cfg_en     = en[0];
    cfg_period = CNT_W'(per);
    cfg_ton    = CNT_W'(ton);
    sync_start = sy;
    p_rst = r; p_v = v; p_ch = ch; p_en = en; p_per = per; p_ton = ton; p_sync = sy;
    for (int c = 0; c < NCH; c++) begin
      e.pwm[c] = out[c];
      e.wrp[c] = active(c) && (pos[c] == a_per[c] - 1);
      e.pnd[c] = pnd[c];
    end
    e.rdy = !pnd[ch];
    exp_q.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      step(1'b0, 1'b0, 0, 0, 0, 0, 1'b0);
    end
  endtask

  task automatic wr(input int ch, input int en, input int per, input int ton);
    step(1'b0, 1'b1, ch, en, per, ton, 1'b0);
  endtask

  task automatic window(input int ch, input int n, input string name,
                        input int exp_hi, input int exp_wr);
    watch_ch = ch;
    cnt_hi = 0;
    cnt_wr = 0;
    counting = 1'b1;
    idle(n);
    counting = 1'b0;
    chk({name, "_high_cycles"}, cnt_hi, exp_hi);
    chk({name, "_wrap_pulses"}, cnt_wr, exp_wr);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("pwm_out", pwm_out, e.pwm);
        chk("wrap", wrap, e.wrp);
        chk("pending", pending, e.pnd);
        chk("cfg_ready", cfg_ready, e.rdy);
      end
    end
  end

  initial begin : driver
    int per, ton;
    counting = 1'b0;
    watch_ch = 0;
    rst = 1'b1; cfg_valid = 1'b0; cfg_ch = '0; cfg_en = 1'b0;
    cfg_period = '0; cfg_ton = '0; sync_start = 1'b0;
    p_rst = 1'b1; p_v = 1'b0; p_ch = 0; p_en = 0; p_per = 0; p_ton = 0; p_sync = 1'b0;

    repeat (3) step(1'b1, 1'b0, 0, 0, 0, 0, 1'b0);
    idle(2);

    // ch0: 7 low / 3 high, one wrap per 10 cycles
    wr(0, 1, 10, 3);
    idle(15);
    window(0, 10, "ch0_p10_t3", 3, 1);

    // ch1: ton=0 constant low, then ton=period constant high
    wr(1, 1, 10, 0);
    idle(12);
    window(1, 10, "ch1_t0", 0, 1);
    wr(1, 1, 10, 10);
    idle(14);
    window(1, 10, "ch1_t10", 10, 1);

    // mid-period rewrite of ch0, then a second write while still pending
    idle(4);
    wr(0, 1, 10, 8);
    wr(0, 1, 10, 5);
    idle(25);

    // sync restart across different periods
    wr(2, 1, 5, 2);
    idle(13);
    step(1'b0, 1'b0, 0, 0, 0, 0, 1'b1);
    idle(20);
    // write and sync in the same cycle on ch1
    step(1'b0, 1'b1, 1, 1, 6, 2, 1'b1);
    idle(20);

    // idle channels: period=0, then disable ch2
    wr(3, 1, 0, 4);
    wr(2, 0, 5, 2);
    idle(15);

    // reset during a high phase
    wr(3, 1, 4, 3);
    idle(7);
    step(1'b1, 1'b0, 0, 0, 0, 0, 1'b0);
    idle(5);

    for (int k = 0; k < 900; k++) begin
      if ($urandom_range(0, 9) == 0) begin
        per = 0;
      end else if ($urandom_range(0, 19) == 0) begin
        per = 255;
      end else begin
        per = int'($urandom_range(1, 12));
      end
      ton = int'($urandom_range(0, per + 2));
      if (ton > 255) ton = 255;
      step(($urandom_range(0, 249) == 0), ($urandom_range(0, 2) == 0),
           int'($urandom_range(0, NCH - 1)), int'($urandom_range(0, 7) != 0),
           per, ton, ($urandom_range(0, 39) == 0));
    end
    idle(3);
    @(negedge clk);
    #1;
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
